rca_share_ctrl: RTL and testbench

Two-requester arbiter and sequencer sharing one `rca` adder instance. It accepts operand pairs from two independent valid/ready request ports and grants the adder to one requester per cycle under round-robin priority. It registers the (WIDTH+1)-bit sum, tagged with the requester id, into a single-entry result buffer drained through a valid/ready response port. It also keeps per-requester saturating transaction counts for debug readout.

---
 rtl/rca_pkg.sv | 16 +
 rtl/rca.sv | 24 ++
 rtl/rca_rr_pick.sv | 30 +++
 rtl/rca_share_ctrl.sv | 119 +++++++++++
 tb/tb_rca_share_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/rca_pkg.sv
// Shared types and constants for the shared-adder controller.
// Buffer states, requester ids and the priority reset value.
package rca_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    typedef logic req_id_t;

    localparam req_id_t REQ0     = 1'b0;
    localparam req_id_t REQ1     = 1'b1;
    localparam req_id_t LAST_RST = REQ1;

endpackage

// File: rtl/rca.sv
// Ripple-carry adder; one full-adder cell per bit.
// The carry chain is the critical path of the controller.
module rca #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    logic [WIDTH:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
        assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_cout = w_c[WIDTH];

endmodule

// File: rtl/rca_rr_pick.sv
// Two-way round-robin pick; the requester that did not go last
// wins a conflict. Operands never reach this logic.
module rca_rr_pick
    import rca_pkg::*;
(
    input  logic    i_valid0,
    input  logic    i_valid1,
    input  req_id_t i_last,
    input  logic    i_can_accept,
    output req_id_t o_grant,
    output logic    o_ready0,
    output logic    o_ready1
);

    req_id_t w_grant;

    always_comb begin
        w_grant = REQ0;
        unique case (1'b1)
            (i_valid0 & i_valid1):  w_grant = req_id_t'(~i_last);
            (i_valid1 & ~i_valid0): w_grant = REQ1;
            default:                w_grant = REQ0;
        endcase
    end

    assign o_grant  = w_grant;
    assign o_ready0 = i_can_accept & i_valid0 & (w_grant == REQ0);
    assign o_ready1 = i_can_accept & i_valid1 & (w_grant == REQ1);

endmodule

// File: rtl/rca_share_ctrl.sv
// Two requesters share one rca adder; results go through a
// single-entry buffer with per-requester saturating counts.
module rca_share_ctrl
    import rca_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH:0]   rsp_sum,
    output logic             rsp_id,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    buf_state_t       r_state;
    logic [WIDTH:0]   r_sum;
    req_id_t          r_id;
    req_id_t          r_last;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    logic             w_can_accept;
    req_id_t          w_grant;
    logic             w_hs0;
    logic             w_hs1;
    logic             w_hs;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_add;
    logic             w_cout;

    assign w_can_accept = (r_state == EMPTY) | ((r_state == FULL) & rsp_ready);

    rca_rr_pick u_pick (
        .i_valid0    (req0_valid),
        .i_valid1    (req1_valid),
        .i_last      (r_last),
        .i_can_accept(w_can_accept),
        .o_grant     (w_grant),
        .o_ready0    (req0_ready),
        .o_ready1    (req1_ready)
    );

    assign w_hs0 = req0_valid & req0_ready;
    assign w_hs1 = req1_valid & req1_ready;
    assign w_hs  = w_hs0 | w_hs1;

    // Mux is steered by the grant, so operands stay off the ready path.
    assign w_a = (w_grant == REQ1) ? req1_a : req0_a;
    assign w_b = (w_grant == REQ1) ? req1_b : req0_b;

    rca #(.WIDTH(WIDTH)) u_rca (
        .i_a   (w_a),
        .i_b   (w_b),
        .i_cin (1'b0),
        .o_sum (w_add),
        .o_cout(w_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
            r_sum   <= '0;
            r_id    <= REQ0;
            r_last  <= LAST_RST;
            r_cnt0  <= '0;
            r_cnt1  <= '0;
        end else begin
            if (w_hs) begin
                r_state <= FULL;
                r_sum   <= {w_cout, w_add};
                r_id    <= w_grant;
                r_last  <= w_grant;
                if (w_hs0 && r_cnt0 != '1) r_cnt0 <= r_cnt0 + 1'b1;
                if (w_hs1 && r_cnt1 != '1) r_cnt1 <= r_cnt1 + 1'b1;
            end else if (r_state == FULL && rsp_ready) begin
                r_state <= EMPTY;
            end
        end
    end

    assign rsp_valid = (r_state == FULL);
    assign rsp_sum   = r_sum;
    assign rsp_id    = r_id;
    assign cnt0      = r_cnt0;
    assign cnt1      = r_cnt1;

`ifdef FORMAL
    logic [WIDTH:0] r_f_exp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_f_exp <= '0;
        else if (w_hs) r_f_exp <= {1'b0, w_a} + {1'b0, w_b};
    end

    always_comb begin
        if (!rst) begin
            assert (!(req0_ready && req1_ready));
            if (rsp_valid) assert (rsp_sum == r_f_exp);
        end
    end

    a_hold: assert property (@(posedge clk) disable iff (rst)
        (rsp_valid && !rsp_ready) |=> ($stable(rsp_sum) && $stable(rsp_id)));
`endif

endmodule

// File: tb/tb_rca_share_ctrl.sv
// Directed bench for rca_share_ctrl with a result scoreboard.
// Expected results are queued at handshake and checked on drain.
module tb_rca_share_ctrl;

    localparam int W = 6;
    localparam int C = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0;
    logic [W-1:0] req0_a = '0;
    logic [W-1:0] req0_b = '0;
    logic         req0_ready;
    logic         req1_valid = 1'b0;
    logic [W-1:0] req1_a = '0;
    logic [W-1:0] req1_b = '0;
    logic         req1_ready;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W:0]   rsp_sum;
    logic         rsp_id;
    logic [C-1:0] cnt0;
    logic [C-1:0] cnt1;

    int total = 0;
    int bad   = 0;
    logic [7:0] sbq[$];

    rca_share_ctrl #(.WIDTH(W), .CNT_W(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0_valid(req0_valid),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .req1_ready(req1_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .cnt0      (cnt0),
        .cnt1      (cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Negedge: check drained result, then queue any accepted pair.
    task automatic sample();
        logic [7:0] e;
        @(negedge clk);
        chk("one_ready", 32'(req0_ready & req1_ready), 0);
        if (rsp_valid && rsp_ready) begin
            total++;
            assert (sbq.size() > 0) else begin
                bad++;
                $error("FAIL sb_empty observed=drain expected=no_drain");
            end
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("sb_sum", 32'(rsp_sum), 32'(e[6:0]));
                chk("sb_id", 32'(rsp_id), 32'(e[7]));
            end
        end
        if (req0_valid && req0_ready) sbq.push_back({1'b0, 7'(req0_a) + 7'(req0_b)});
        if (req1_valid && req1_ready) sbq.push_back({1'b1, 7'(req1_a) + 7'(req1_b)});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sbq.delete();
    endtask

    logic [W-1:0] ta [4] = '{6'd0, 6'd1, 6'd32, 6'd63};
    logic [W-1:0] tb [4] = '{6'd0, 6'd63, 6'd32, 6'd0};
    logic [W:0]   te [4] = '{7'd0, 7'd64, 7'd64, 7'd63};

    initial begin
        // reset state
        #2;
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_sum", 32'(rsp_sum), 0);
        chk("rst_id", 32'(rsp_id), 0);
        chk("rst_cnt0", 32'(cnt0), 0);
        chk("rst_cnt1", 32'(cnt1), 0);
        do_reset();

        // single request 63+63
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 6'd63; req0_b = 6'd63;
        sample();
        chk("t1_ready0", 32'(req0_ready), 1);
        tick();
        req0_valid = 1'b0;
        chk("t1_valid", 32'(rsp_valid), 1);
        chk("t1_sum", 32'(rsp_sum), 126);
        chk("t1_id", 32'(rsp_id), 0);
        chk("t1_cnt0", 32'(cnt0), 1);
        sample();
        tick();
        chk("t1_drain", 32'(rsp_valid), 0);

        // conflict fairness
        do_reset();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 6'd3;  req0_b = 6'd4;
        req1_valid = 1'b1; req1_a = 6'd20; req1_b = 6'd40;
        for (int i = 0; i < 6; i++) begin
            sample();
            chk("fair_r0", 32'(req0_ready), 32'(i % 2 == 0));
            chk("fair_r1", 32'(req1_ready), 32'(i % 2 == 1));
            tick();
            chk("fair_id", 32'(rsp_id), 32'(i % 2));
            if (i % 2 == 0) begin
                req0_a = 6'($urandom_range(0, 63));
                req0_b = 6'($urandom_range(0, 63));
            end else begin
                req1_a = 6'($urandom_range(0, 63));
                req1_b = 6'($urandom_range(0, 63));
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("fair_cnt0", 32'(cnt0), 3);
        chk("fair_cnt1", 32'(cnt1), 3);
        sample();
        tick();

        // backpressure
        do_reset();
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 6'd5; req0_b = 6'd7;
        sample();
        chk("bp_ready0", 32'(req0_ready), 1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 6'd10; req1_b = 6'd20;
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("bp_ready1", 32'(req1_ready), 0);
            chk("bp_valid", 32'(rsp_valid), 1);
            chk("bp_sum", 32'(rsp_sum), 12);
            chk("bp_id", 32'(rsp_id), 0);
            tick();
        end
        rsp_ready = 1'b1;
        sample();
        chk("bp_accept", 32'(req1_ready), 1);
        tick();
        req1_valid = 1'b0;
        chk("bp_new_sum", 32'(rsp_sum), 30);
        chk("bp_new_id", 32'(rsp_id), 1);
        sample();
        tick();

        // zero and carry edges
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req0_valid = 1'b1; req0_a = ta[i]; req0_b = tb[i];
            sample();
            chk("edge_ready", 32'(req0_ready), 1);
            tick();
            chk("edge_sum", 32'(rsp_sum), 32'(te[i]));
        end
        req0_valid = 1'b0;
        sample();
        tick();

        // counter saturation on requester 1
        do_reset();
        rsp_ready = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            req1_a = 6'(i * 5); req1_b = 6'(63 - i);
            sample();
            chk("sat_ready1", 32'(req1_ready), 1);
            tick();
            if (i == 6) chk("sat_cnt1_7", 32'(cnt1), 7);
        end
        req1_valid = 1'b0;
        chk("sat_cnt1", 32'(cnt1), 7);
        chk("sat_cnt0", 32'(cnt0), 0);
        sample();
        tick();

        // reset mid-operation
        do_reset();
        rsp_ready = 1'b0;
        req1_valid = 1'b1; req1_a = 6'd9; req1_b = 6'd1;
        sample();
        tick();
        req0_valid = 1'b1; req0_a = 6'd2; req0_b = 6'd2;
        chk("mid_full", 32'(rsp_valid), 1);
        rst = 1'b1;
        #1;
        chk("mid_valid", 32'(rsp_valid), 0);
        chk("mid_sum", 32'(rsp_sum), 0);
        chk("mid_cnt1", 32'(cnt1), 0);
        sbq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        sample();
        chk("mid_r0", 32'(req0_ready), 1);
        chk("mid_r1", 32'(req1_ready), 0);
        tick();
        chk("mid_id", 32'(rsp_id), 0);
        sample();
        chk("mid_r1_next", 32'(req1_ready), 1);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        sample();
        tick();
        chk("sb_left", 32'(sbq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
